nd_1ton_router: RTL and testbench

//  Parametrised successor of the 1-to-2 node splitter: one inbound message channel fanned out to
//  NUM_OUT outbound channels, routed by address range on the message dst field. Each output has
//  its own FSZ-deep FIFO and an independent 4-phase req/ack handshake. Sits in the node network

---
 rtl/nd_1ton_router.sv | 127 ++++++++++++
 tb/tb_nd_1ton_router.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nd_1ton_router.sv
// nd_1ton_router: address-range router to NUM_OUT FIFO-buffered 4-phase outputs; define NS_1TON_BCAST_EN to broadcast dst==all-ones
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif
module nd_1ton_router #(
  parameter int NUM_OUT = 4,
  parameter int FSZ = 4,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE,
  parameter logic [NUM_OUT*ASZ-1:0] RANGE_LO = '0,
  parameter logic [NUM_OUT*ASZ-1:0] RANGE_HI = '0,
  parameter int DFLT_OUT = 0,
  parameter int REQ_CKS = `NS_REQ_CKS,
  parameter int ACK_CKS = `NS_ACK_CKS
) (
  input  logic                   gch_clk,
  input  logic                   gch_reset,
  output logic                   gch_ready,
  input  logic                   rcv0_req,
  output logic                   rcv0_ack,
  input  logic [ASZ-1:0]         rcv0_src,
  input  logic [ASZ-1:0]         rcv0_dst,
  input  logic [DSZ-1:0]         rcv0_dat,
  input  logic [RSZ-1:0]         rcv0_red,
  output logic [NUM_OUT-1:0]     snd_req,
  input  logic [NUM_OUT-1:0]     snd_ack,
  output logic [NUM_OUT*ASZ-1:0] snd_src,
  output logic [NUM_OUT*ASZ-1:0] snd_dst,
  output logic [NUM_OUT*DSZ-1:0] snd_dat,
  output logic [NUM_OUT*RSZ-1:0] snd_red
);
  localparam int MW = 2*ASZ + DSZ + RSZ;
  localparam int AW = $clog2(FSZ);
  localparam int CW = $clog2(FSZ + 1);
  localparam int TW = $clog2(NUM_OUT);
  typedef enum logic {IDLE, ACKD} in_st_t;
  typedef enum logic [1:0] {EMPTY, REQ, WAIT} out_st_t;
  logic rdy, accept, bcast;
  logic [NUM_OUT:0] raw, db;
  logic [NUM_OUT-1:0] full, mask, push, pop;
  logic [TW-1:0] tgt;
  logic [MW-1:0] msg_in;
  in_st_t ist, ist_n;
  assign raw = {snd_ack, rcv0_req};
  assign msg_in = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
  always_ff @(posedge gch_clk or negedge gch_reset)
    if (!gch_reset) {rdy, gch_ready} <= '0;
    else {rdy, gch_ready} <= {1'b1, rdy};
  // bit 0 debounces rcv0_req, bit i+1 debounces snd_ack[i]; a high is valid after CK straight cycles
  for (genvar g = 0; g <= NUM_OUT; g++) begin : g_db
    localparam logic [31:0] CK = g == 0 ? REQ_CKS : ACK_CKS;
    logic [31:0] c;
    logic d;
    always_ff @(posedge gch_clk or negedge gch_reset)
      if (!gch_reset) begin
        c <= '0;
        d <= 1'b0;
      end else begin
        c <= !raw[g] ? '0 : c == CK ? c : c + 32'd1;
        d <= raw[g] && c >= CK - 32'd1;
      end
    assign db[g] = d;
  end
  // iterate downwards so the lowest matching range wins
  always_comb begin
    tgt = TW'(DFLT_OUT);
    for (int i = NUM_OUT - 1; i >= 0; i--)
      if (rcv0_dst >= RANGE_LO[i*ASZ +: ASZ] && rcv0_dst <= RANGE_HI[i*ASZ +: ASZ]) tgt = TW'(i);
  end
`ifdef NS_1TON_BCAST_EN
  assign bcast = &rcv0_dst;
`else
  assign bcast = 1'b0;
`endif
  assign mask = bcast ? '1 : NUM_OUT'(1) << tgt;
  assign accept = ist == IDLE && gch_ready && db[0] && !(|(mask & full));
  assign push = accept ? mask : '0;
  assign rcv0_ack = ist == ACKD;
  always_comb ist_n = ist == IDLE ? (accept ? ACKD : IDLE) : (db[0] ? ACKD : IDLE);
  always_ff @(posedge gch_clk or negedge gch_reset)
    if (!gch_reset) ist <= IDLE;
    else ist <= ist_n;
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    logic [MW-1:0] mem [FSZ];
    logic [MW-1:0] head;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic load;
    out_st_t st, st_n;
    assign full[g] = cnt == CW'(FSZ);
    assign load = st == EMPTY && cnt != '0 && !db[g+1];
    assign pop[g] = st == REQ && db[g+1];
    assign snd_req[g] = st == REQ;
    always_comb st_n = st == EMPTY ? (load ? REQ : EMPTY) : st == REQ ? (pop[g] ? WAIT : REQ) : (db[g+1] ? WAIT : EMPTY);
    always_ff @(posedge gch_clk)
      if (push[g]) mem[wp] <= msg_in;
    // head stays in the FIFO until the ack pops it, so fields are stable for the whole request
    always_ff @(posedge gch_clk or negedge gch_reset)
      if (!gch_reset) begin
        st <= EMPTY;
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        head <= '0;
      end else begin
        st <= st_n;
        wp <= wp + AW'(push[g]);
        rp <= rp + AW'(pop[g]);
        cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
        if (load) head <= mem[rp];
      end
    assign {snd_src[g*ASZ +: ASZ], snd_dst[g*ASZ +: ASZ], snd_dat[g*DSZ +: DSZ], snd_red[g*RSZ +: RSZ]} = head;
  end
endmodule

// File: tb/tb_nd_1ton_router.sv
// tb_nd_1ton_router: directed and randomized checks of nd_1ton_router against a queue-based delivery model
module tb_nd_1ton_router;
  localparam int NO = 4;
  logic gch_clk = 0, gch_reset = 1;
  logic gch_ready, rcv0_req = 0, rcv0_ack;
  logic [7:0] rcv0_src = 0, rcv0_dst = 0, rcv0_dat = 0;
  logic [3:0] rcv0_red = 0;
  logic [NO-1:0] snd_req, snd_ack = 0, hold = 0, rx_busy = 0;
  logic [31:0] snd_src, snd_dst, snd_dat;
  logic [15:0] snd_red;
  logic [27:0] exp_q [NO][$];
  logic [7:0] seq4 [8] = '{8'd1, 8'd9, 8'd1, 8'd9, 8'd1, 8'd9, 8'd9, 8'd9};
  int n_cmp = 0, n_err = 0, n_rx = 0, n_push = 0, k;
  bit ok;
  always #5 gch_clk = ~gch_clk;
  nd_1ton_router #(.NUM_OUT(NO), .FSZ(4), .ASZ(8), .DSZ(8), .RSZ(4),
    .RANGE_LO({8'd12, 8'd8, 8'd4, 8'd0}), .RANGE_HI({8'd15, 8'd11, 8'd7, 8'd3}),
    .DFLT_OUT(2), .REQ_CKS(2), .ACK_CKS(2)) dut (
    .gch_clk(gch_clk), .gch_reset(gch_reset), .gch_ready(gch_ready),
    .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack), .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst),
    .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red), .snd_req(snd_req), .snd_ack(snd_ack),
    .snd_src(snd_src), .snd_dst(snd_dst), .snd_dat(snd_dat), .snd_red(snd_red));
  function automatic int route(input logic [7:0] d);
    return d < 16 ? int'(d) / 4 : 2;
  endfunction
  function automatic int pending();
    pending = 0;
    for (int i = 0; i < NO; i++) pending += exp_q[i].size();
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock of time: every unheld receiver checks a new request against the model and acks it
  task automatic tick();
    @(negedge gch_clk);
    for (int i = 0; i < NO; i++)
      if (!gch_reset) begin
        rx_busy[i] = 0;
        snd_ack[i] = 0;
        exp_q[i].delete();
      end else if (!rx_busy[i] && snd_req[i] && !hold[i]) begin
        logic [27:0] e;
        e = 'x;
        if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
        chk($sformatf("rx%0d", i), {snd_src[i*8 +: 8], snd_dst[i*8 +: 8], snd_dat[i*8 +: 8], snd_red[i*4 +: 4]}, e);
        rx_busy[i] = 1;
        snd_ack[i] = 1;
        n_rx++;
      end else if (rx_busy[i] && !snd_req[i]) begin
        snd_ack[i] = 0;
        rx_busy[i] = 0;
      end
  endtask
  task automatic put(input logic [7:0] d, input logic [7:0] dat);
    rcv0_src = 8'($urandom);
    rcv0_dst = d;
    rcv0_dat = dat;
    rcv0_red = 4'($urandom);
    rcv0_req = 1;
  endtask
  task automatic wait_ack(input int budget, output bit got);
    got = 0;
    for (int j = 0; j < budget && !got; j++) begin
      tick();
      got = rcv0_ack;
    end
    if (got) begin
`ifdef NS_1TON_BCAST_EN
      if (&rcv0_dst) begin
        for (int i = 0; i < NO; i++) exp_q[i].push_back({rcv0_src, rcv0_dst, rcv0_dat, rcv0_red});
        n_push += NO;
      end else
`endif
      begin
        exp_q[route(rcv0_dst)].push_back({rcv0_src, rcv0_dst, rcv0_dat, rcv0_red});
        n_push++;
      end
    end
  endtask
  task automatic drop(input string tag);
    int j = 0;
    rcv0_req = 0;
    while (j < 50 && rcv0_ack) begin
      tick();
      j++;
    end
    chk(tag, rcv0_ack, 0);
  endtask
  task automatic send(input logic [7:0] d);
    bit got;
    put(d, 8'($urandom));
    wait_ack(40, got);
    if (!got) begin
      hold = '0;
      wait_ack(200, got);
    end
    chk("send_ack", got, 1);
    drop("send_unack");
  endtask
  task automatic drain(input string tag);
    int j = 0;
    while (j < 500 && (pending() != 0 || rx_busy != 0)) begin
      tick();
      j++;
    end
    chk(tag, pending(), 0);
  endtask
  task automatic wait_ready(input string tag);
    int j = 0;
    while (j < 10 && !gch_ready) begin
      tick();
      j++;
    end
    chk(tag, gch_ready, 1);
  endtask
  initial begin
    #1 gch_reset = 0;
    repeat (3) @(negedge gch_clk);
    chk("rst_req", snd_req, 0);
    chk("rst_ack", rcv0_ack, 0);
    chk("rst_rdy", gch_ready, 0);
    chk("rst_dat", snd_dat, 0);
    gch_reset = 1;
    wait_ready("init_rdy");
    put(8'd5, 8'hA5);
    wait_ack(40, ok);
    chk("t1_ack", ok, 1);
    chk("t1_pre", snd_req, 0);
    tick();
    chk("t1_req", snd_req, 4'b0010);
    chk("t1_dat", snd_dat[15:8], 8'hA5);
    drop("t1_drop");
    drain("t1_drain");
    put(8'd20, 8'h5A);
    wait_ack(40, ok);
    chk("t2_ack", ok, 1);
    tick();
    chk("t2_req", snd_req, 4'b0100);
    drop("t2_drop");
    drain("t2_drain");
    hold = 4'b0001;
    repeat (4) send(8'd1);
    put(8'd1, 8'h55);
    wait_ack(30, ok);
    chk("t3_stall", ok, 0);
    chk("t3_noack", rcv0_ack, 0);
    hold = 0;
    wait_ack(100, ok);
    chk("t3_late", ok, 1);
    drop("t3_drop");
    drain("t3_drain");
    hold = 4'b0001;
    for (int i = 0; i < 8; i++) send(seq4[i]);
    k = 0;
    while (k < 200 && (exp_q[2].size() != 0 || rx_busy[2])) begin
      tick();
      k++;
    end
    chk("t4_out2", exp_q[2].size(), 0);
    chk("t4_out0_held", exp_q[0].size(), 3);
    hold = 0;
    drain("t4_drain");
`ifdef NS_1TON_BCAST_EN
    put(8'hFF, 8'h3C);
    wait_ack(40, ok);
    chk("t5_ack", ok, 1);
    tick();
    chk("t5_req", snd_req, 4'hF);
    drop("t5_drop");
    drain("t5_drain");
    hold = 4'b1000;
    repeat (4) send(8'd12);
    put(8'hFF, 8'hC3);
    wait_ack(30, ok);
    chk("t5_stall", ok, 0);
    chk("t5_none", snd_req[2:0], 0);
    hold = 0;
    wait_ack(100, ok);
    chk("t5_late", ok, 1);
    drop("t5_drop2");
    drain("t5_drain2");
`endif
    repeat (60) begin
      hold = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'd0;
      send($urandom_range(0, 7) == 0 ? 8'hFF : 8'($urandom_range(0, 23)));
    end
    hold = 0;
    drain("rnd_drain");
    chk("rnd_count", n_rx, n_push);
    hold = 4'b0010;
    send(8'd5);
    k = 0;
    while (k < 20 && !snd_req[1]) begin
      tick();
      k++;
    end
    chk("t6_req", snd_req[1], 1);
    put(8'd9, 8'h99);
    wait_ack(40, ok);
    chk("t6_ack", ok, 1);
    #2 gch_reset = 0;
    #1;
    chk("t6_req_drop", snd_req, 0);
    chk("t6_ack_drop", rcv0_ack, 0);
    chk("t6_rdy_drop", gch_ready, 0);
    rcv0_req = 0;
    hold = 0;
    repeat (3) tick();
    gch_reset = 1;
    wait_ready("t6_rdy");
    k = 0;
    repeat (10) begin
      tick();
      if (snd_req != 0) k++;
    end
    chk("t6_empty", k, 0);
    send(8'd14);
    drain("t6_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
